// File: rtl/program_load_sequencer_if.sv
// Bundle between the UART controller, the program load sequencer and the instruction memory.
// The sequencer takes the slave side; whoever feeds words and watches status takes the master side.
interface program_load_sequencer_if #(
    parameter int ADDRESS_WIDTH = 11
);
    logic                     memory_wr_in;
    logic [ADDRESS_WIDTH-1:0] memory_address_in;
    logic [15:0]              instruction_in;
    logic                     restart_in;
    logic                     imem_we_out;
    logic [ADDRESS_WIDTH-1:0] imem_address_out;
    logic [15:0]              imem_data_out;
    logic                     cpu_reset_out;
    logic                     load_done_out;
    logic                     load_error_out;
    logic [1:0]               error_code_out;
    logic [ADDRESS_WIDTH:0]   word_count_out;
    logic [15:0]              checksum_out;

    modport master (
        output memory_wr_in, memory_address_in, instruction_in, restart_in,
        input  imem_we_out, imem_address_out, imem_data_out, cpu_reset_out,
               load_done_out, load_error_out, error_code_out, word_count_out, checksum_out
    );

    modport slave (
        input  memory_wr_in, memory_address_in, instruction_in, restart_in,
        output imem_we_out, imem_address_out, imem_data_out, cpu_reset_out,
               load_done_out, load_error_out, error_code_out, word_count_out, checksum_out
    );
endinterface

// File: rtl/program_load_sequencer.sv
// Validates the program word stream from the UART controller, writes data words to instruction
// memory one cycle after their strobe, and keeps the CPU in reset until a checksummed load completes.
module program_load_sequencer #(
    parameter int          ADDRESS_WIDTH = 11,
    parameter logic [15:0] END_MARKER    = 16'hFFFF
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    program_load_sequencer_if.slave  bus
);
    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [1:0] ERROR = 2'd3;

    localparam logic [1:0] CODE_NONE     = 2'd0;
    localparam logic [1:0] CODE_ADDRESS  = 2'd1;
    localparam logic [1:0] CODE_OVERFLOW = 2'd2;
    localparam logic [1:0] CODE_CHECKSUM = 2'd3;

    // Memory is full once every address has been written exactly once.
    localparam logic [ADDRESS_WIDTH:0] FULL_COUNT = {1'b1, {ADDRESS_WIDTH{1'b0}}};

    logic [1:0]               state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0] expected_address_reg, expected_address_next;
    logic [ADDRESS_WIDTH:0]   word_count_reg, word_count_next;
    logic [15:0]              checksum_reg, checksum_next;
    logic [1:0]               error_code_reg, error_code_next;
    logic                     imem_we_reg, imem_we_next;
    logic [ADDRESS_WIDTH-1:0] imem_address_reg, imem_address_next;
    logic [15:0]              imem_data_reg, imem_data_next;

    logic address_ok;
    logic is_marker;

    assign address_ok = (bus.memory_address_in == expected_address_reg);
    assign is_marker  = (bus.instruction_in == END_MARKER);

    always_comb begin
        state_next            = state_reg;
        expected_address_next = expected_address_reg;
        word_count_next       = word_count_reg;
        checksum_next         = checksum_reg;
        error_code_next       = error_code_reg;
        imem_we_next          = 1'b0;
        imem_address_next     = imem_address_reg;
        imem_data_next        = imem_data_reg;

        // Restart beats a same-cycle word: the word is simply dropped.
        if (bus.restart_in) begin
            state_next            = LOAD;
            expected_address_next = '0;
            word_count_next       = '0;
            checksum_next         = '0;
            error_code_next       = CODE_NONE;
        end else if (bus.memory_wr_in) begin
            case (state_reg)
                LOAD: begin
                    if (!address_ok) begin
                        state_next      = ERROR;
                        error_code_next = CODE_ADDRESS;
                    end else if (is_marker) begin
                        state_next            = CHECK;
                        expected_address_next = expected_address_reg + 1'b1;
                    end else if (word_count_reg == FULL_COUNT) begin
                        state_next      = ERROR;
                        error_code_next = CODE_OVERFLOW;
                    end else begin
                        imem_we_next          = 1'b1;
                        imem_address_next     = bus.memory_address_in;
                        imem_data_next        = bus.instruction_in;
                        checksum_next         = checksum_reg + bus.instruction_in;
                        word_count_next       = word_count_reg + 1'b1;
                        expected_address_next = expected_address_reg + 1'b1;
                    end
                end
                CHECK: begin
                    if (!address_ok) begin
                        state_next      = ERROR;
                        error_code_next = CODE_ADDRESS;
                    end else if (bus.instruction_in == checksum_reg) begin
                        state_next = DONE;
                    end else begin
                        state_next      = ERROR;
                        error_code_next = CODE_CHECKSUM;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_reg            <= LOAD;
            expected_address_reg <= '0;
            word_count_reg       <= '0;
            checksum_reg         <= '0;
            error_code_reg       <= CODE_NONE;
            imem_we_reg          <= 1'b0;
            imem_address_reg     <= '0;
            imem_data_reg        <= '0;
        end else begin
            state_reg            <= state_next;
            expected_address_reg <= expected_address_next;
            word_count_reg       <= word_count_next;
            checksum_reg         <= checksum_next;
            error_code_reg       <= error_code_next;
            imem_we_reg          <= imem_we_next;
            imem_address_reg     <= imem_address_next;
            imem_data_reg        <= imem_data_next;
        end
    end

    assign bus.imem_we_out      = imem_we_reg;
    assign bus.imem_address_out = imem_address_reg;
    assign bus.imem_data_out    = imem_data_reg;
    assign bus.cpu_reset_out    = (state_reg != DONE);
    assign bus.load_done_out    = (state_reg == DONE);
    assign bus.load_error_out   = (state_reg == ERROR);
    assign bus.error_code_out   = error_code_reg;
    assign bus.word_count_out   = word_count_reg;
    assign bus.checksum_out     = checksum_reg;
endmodule

// File: tb/tb_program_load_sequencer.sv
// Drives two sequencers (11-bit and 2-bit address) with directed word streams and checks every
// cycle against a behavioural load model, plus literal expectations after each scenario.
module tb_program_load_sequencer;
    logic clk = 1'b0;
    logic reset_in = 1'b1;
    always #5 clk = ~clk;

    program_load_sequencer_if #(.ADDRESS_WIDTH(11)) bus_a ();
    program_load_sequencer_if #(.ADDRESS_WIDTH(2))  bus_b ();

    program_load_sequencer #(.ADDRESS_WIDTH(11), .END_MARKER(16'hFFFF)) dut_a (
        .clock_in (clk),
        .reset_in (reset_in),
        .bus      (bus_a.slave)
    );

    program_load_sequencer #(.ADDRESS_WIDTH(2), .END_MARKER(16'hFFFF)) dut_b (
        .clock_in (clk),
        .reset_in (reset_in),
        .bus      (bus_b.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    // Behavioural model: phase names, integer counters, one entry per DUT.
    localparam int P_LOAD = 0, P_CHECK = 1, P_DONE = 2, P_ERROR = 3;
    int aw[2] = '{11, 2};
    int ph[2], exp_addr[2], cnt[2], cs[2], code[2], m_we[2], m_wa[2], m_wd[2];

    typedef struct { int addr; int data; } wr_t;
    wr_t wlog_a[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic mstep(input int id, input logic rst, input logic wr, input int addr,
                         input int data, input logic rs);
        int full;
        full = 1 << aw[id];
        if (rst) begin
            ph[id] = P_LOAD; exp_addr[id] = 0; cnt[id] = 0; cs[id] = 0; code[id] = 0;
            m_we[id] = 0; m_wa[id] = 0; m_wd[id] = 0;
        end else begin
            m_we[id] = 0;
            if (rs) begin
                ph[id] = P_LOAD; exp_addr[id] = 0; cnt[id] = 0; cs[id] = 0; code[id] = 0;
            end else if (wr && ph[id] == P_LOAD) begin
                if (addr != exp_addr[id]) begin
                    ph[id] = P_ERROR; code[id] = 1;
                end else if (data == 'hFFFF) begin
                    ph[id] = P_CHECK; exp_addr[id] = (exp_addr[id] + 1) % full;
                end else if (cnt[id] == full) begin
                    ph[id] = P_ERROR; code[id] = 2;
                end else begin
                    m_we[id] = 1; m_wa[id] = addr; m_wd[id] = data;
                    cs[id] = (cs[id] + data) % 65536;
                    cnt[id] = cnt[id] + 1;
                    exp_addr[id] = (exp_addr[id] + 1) % full;
                end
            end else if (wr && ph[id] == P_CHECK) begin
                if (addr != exp_addr[id]) begin
                    ph[id] = P_ERROR; code[id] = 1;
                end else if (data == cs[id]) begin
                    ph[id] = P_DONE;
                end else begin
                    ph[id] = P_ERROR; code[id] = 3;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        mstep(0, reset_in, bus_a.memory_wr_in, int'(bus_a.memory_address_in),
              int'(bus_a.instruction_in), bus_a.restart_in);
        mstep(1, reset_in, bus_b.memory_wr_in, int'(bus_b.memory_address_in),
              int'(bus_b.instruction_in), bus_b.restart_in);
    end

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("a.we",    32'(bus_a.imem_we_out),      32'(m_we[0]));
            chk("a.waddr", 32'(bus_a.imem_address_out), 32'(m_wa[0]));
            chk("a.wdata", 32'(bus_a.imem_data_out),    32'(m_wd[0]));
            chk("a.cpurst",32'(bus_a.cpu_reset_out),    32'(ph[0] != P_DONE));
            chk("a.done",  32'(bus_a.load_done_out),    32'(ph[0] == P_DONE));
            chk("a.error", 32'(bus_a.load_error_out),   32'(ph[0] == P_ERROR));
            chk("a.code",  32'(bus_a.error_code_out),   32'(code[0]));
            chk("a.count", 32'(bus_a.word_count_out),   32'(cnt[0]));
            chk("a.csum",  32'(bus_a.checksum_out),     32'(cs[0]));
            chk("b.we",    32'(bus_b.imem_we_out),      32'(m_we[1]));
            chk("b.waddr", 32'(bus_b.imem_address_out), 32'(m_wa[1]));
            chk("b.wdata", 32'(bus_b.imem_data_out),    32'(m_wd[1]));
            chk("b.cpurst",32'(bus_b.cpu_reset_out),    32'(ph[1] != P_DONE));
            chk("b.done",  32'(bus_b.load_done_out),    32'(ph[1] == P_DONE));
            chk("b.error", 32'(bus_b.load_error_out),   32'(ph[1] == P_ERROR));
            chk("b.code",  32'(bus_b.error_code_out),   32'(code[1]));
            chk("b.count", 32'(bus_b.word_count_out),   32'(cnt[1]));
            chk("b.csum",  32'(bus_b.checksum_out),     32'(cs[1]));
            if (bus_a.imem_we_out)
                wlog_a.push_back('{int'(bus_a.imem_address_out), int'(bus_a.imem_data_out)});
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input int id, input int addr, input int data);
        if (id == 0) begin
            bus_a.memory_wr_in = 1'b1; bus_a.memory_address_in = addr[10:0];
            bus_a.instruction_in = data[15:0];
        end else begin
            bus_b.memory_wr_in = 1'b1; bus_b.memory_address_in = addr[1:0];
            bus_b.instruction_in = data[15:0];
        end
        $display("word dut%0d addr=%0h data=%04h", id, addr, data);
        step();
        bus_a.memory_wr_in = 1'b0;
        bus_b.memory_wr_in = 1'b0;
    endtask

    task automatic restart(input int id);
        if (id == 0) bus_a.restart_in = 1'b1; else bus_b.restart_in = 1'b1;
        $display("restart dut%0d", id);
        step();
        bus_a.restart_in = 1'b0;
        bus_b.restart_in = 1'b0;
        wlog_a.delete();
    endtask

    initial begin
        bus_a.memory_wr_in = 1'b0; bus_a.memory_address_in = '0;
        bus_a.instruction_in = '0; bus_a.restart_in = 1'b0;
        bus_b.memory_wr_in = 1'b0; bus_b.memory_address_in = '0;
        bus_b.instruction_in = '0; bus_b.restart_in = 1'b0;
        repeat (2) step();
        reset_in = 1'b0;
        check_en = 1'b1;
        step();
        chk("reset.cpurst", 32'(bus_a.cpu_reset_out), 32'd1);
        chk("reset.count",  32'(bus_a.word_count_out), 32'd0);

        // Normal two-word program.
        word(0, 0, 'h1234); word(0, 1, 'h0001); word(0, 2, 'hFFFF); word(0, 3, 'h1235);
        step();
        chk("t1.nwrites", 32'(wlog_a.size()), 32'd2);
        if (wlog_a.size() == 2) begin
            chk("t1.w0addr", 32'(wlog_a[0].addr), 32'h0);
            chk("t1.w0data", 32'(wlog_a[0].data), 32'h1234);
            chk("t1.w1addr", 32'(wlog_a[1].addr), 32'h1);
            chk("t1.w1data", 32'(wlog_a[1].data), 32'h0001);
        end
        chk("t1.count",  32'(bus_a.word_count_out), 32'd2);
        chk("t1.done",   32'(bus_a.load_done_out),  32'd1);
        chk("t1.cpurst", 32'(bus_a.cpu_reset_out),  32'd0);

        // Checksum wraps modulo 2^16.
        restart(0);
        word(0, 0, 'h8000); word(0, 1, 'h8001); word(0, 2, 'hFFFF); word(0, 3, 'h0001);
        step();
        chk("t2.csum", 32'(bus_a.checksum_out),  32'h0001);
        chk("t2.done", 32'(bus_a.load_done_out), 32'd1);

        // Address gap.
        restart(0);
        word(0, 0, 'h0010); word(0, 2, 'h0020);
        step();
        chk("t3.code",    32'(bus_a.error_code_out), 32'd1);
        chk("t3.cpurst",  32'(bus_a.cpu_reset_out),  32'd1);
        chk("t3.nwrites", 32'(wlog_a.size()),        32'd1);

        // Bad checksum.
        restart(0);
        word(0, 0, 'h0005); word(0, 1, 'hFFFF); word(0, 2, 'h0006);
        step();
        chk("t4.code",    32'(bus_a.error_code_out), 32'd3);
        chk("t4.error",   32'(bus_a.load_error_out), 32'd1);
        chk("t4.nwrites", 32'(wlog_a.size()),        32'd1);

        // Overflow on the 2-bit instance, then a full legal program.
        for (int i = 0; i < 4; i++) word(1, i, i + 1);
        word(1, 0, 'h0005);
        step();
        chk("t5.code",  32'(bus_b.error_code_out), 32'd2);
        chk("t5.count", 32'(bus_b.word_count_out), 32'd4);
        restart(1);
        for (int i = 0; i < 4; i++) word(1, i, i + 1);
        word(1, 0, 'hFFFF); word(1, 1, 'h000A);
        step();
        chk("t5b.done",  32'(bus_b.load_done_out),  32'd1);
        chk("t5b.count", 32'(bus_b.word_count_out), 32'd4);

        // Empty program, then restart colliding with a word.
        restart(0);
        word(0, 0, 'hFFFF); word(0, 1, 'h0000);
        step();
        chk("t6.done",  32'(bus_a.load_done_out),  32'd1);
        chk("t6.count", 32'(bus_a.word_count_out), 32'd0);
        bus_a.restart_in = 1'b1;
        word(0, 0, 'h0777);
        bus_a.restart_in = 1'b0;
        step();
        chk("t6.cpurst",  32'(bus_a.cpu_reset_out),  32'd1);
        chk("t6.count",   32'(bus_a.word_count_out), 32'd0);
        chk("t6.loaddone",32'(bus_a.load_done_out),  32'd0);
        chk("t6.nwrites", 32'(wlog_a.size()),        32'd0);

        // Reset mid-load cancels the pending write.
        word(0, 0, 'h1111);
        reset_in = 1'b1;
        $display("reset asserted with word pending");
        word(0, 1, 'h2222);
        reset_in = 1'b0;
        chk("t7.we",     32'(bus_a.imem_we_out),    32'd0);
        chk("t7.data",   32'(bus_a.imem_data_out),  32'd0);
        chk("t7.count",  32'(bus_a.word_count_out), 32'd0);
        chk("t7.csum",   32'(bus_a.checksum_out),   32'd0);
        chk("t7.cpurst", 32'(bus_a.cpu_reset_out),  32'd1);
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
